battleship_board_ctrl: RTL and testbench

- Parametrised two-board (player / PC) battleship grid engine; successor of the fixed 5x5 board logic.
- Serves placement, attack and clear commands from the game FSM over a valid/ready command port.
- Returns a one-cycle coded response for each command and exposes a registered cell-read port for the VGA renderer.
- Adds bounds, overlap and repeat-attack checking, vertical ships, hit counters and a defeat flag.

---
 rtl/battleship_board_ctrl_if.sv | 26 ++
 rtl/battleship_board_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_battleship_board_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/battleship_board_ctrl_if.sv
// Command/response port of the battleship board engine.
// The game FSM is the master; the board engine is the slave.
interface battleship_board_ctrl_if #(
  parameter int COORD_W = 3
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic               cmd_board;
  logic [COORD_W-1:0] cmd_row;
  logic [COORD_W-1:0] cmd_col;
  logic [2:0]         cmd_len;
  logic               cmd_vert;
  logic               resp_valid;
  logic [2:0]         resp_code;

  modport master (
    output cmd_valid, cmd_op, cmd_board, cmd_row, cmd_col, cmd_len, cmd_vert,
    input  cmd_ready, resp_valid, resp_code
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_board, cmd_row, cmd_col, cmd_len, cmd_vert,
    output cmd_ready, resp_valid, resp_code
  );
endinterface

// File: rtl/battleship_board_ctrl.sv
// Two-board battleship grid engine: placement with bounds/overlap checks,
// attacks with repeat detection, board clear, hit counters and a registered
// cell-read port for the renderer. Cells live in one array, player board
// first, each board stored row-major.
module battleship_board_ctrl #(
  parameter int BOARD_N   = 5,
  parameter int COORD_W   = 3,
  parameter int MAX_SHIPS = 5,
  parameter int MAX_LEN   = 3
) (
  input  logic                clk,
  input  logic                rst,
  battleship_board_ctrl_if.slave cmd,
  input  logic                rd_board,
  input  logic [COORD_W-1:0]  rd_row,
  input  logic [COORD_W-1:0]  rd_col,
  output logic [1:0]          rd_cell,
  output logic [1:0][2:0]     ships_placed,
  output logic [1:0][4:0]     cells_left,
  output logic [1:0]          defeated
);

  localparam int N2    = BOARD_N * BOARD_N;
  localparam int CELLS = 2 * N2;
  localparam int IDX_W = $clog2(CELLS);
  localparam int CNT_W = $clog2(N2 + 1);

  localparam logic [1:0] WATER     = 2'b00;
  localparam logic [1:0] SHIP      = 2'b01;
  localparam logic [1:0] HIT_SHIP  = 2'b10;
  localparam logic [1:0] HIT_WATER = 2'b11;

  localparam logic [2:0] R_PLACED      = 3'b000;
  localparam logic [2:0] R_ERR_BOUNDS  = 3'b001;
  localparam logic [2:0] R_ERR_OVERLAP = 3'b010;
  localparam logic [2:0] R_ERR_FULL    = 3'b011;
  localparam logic [2:0] R_HIT         = 3'b100;
  localparam logic [2:0] R_MISS        = 3'b101;
  localparam logic [2:0] R_REPEAT      = 3'b110;
  localparam logic [2:0] R_ERR_OP      = 3'b111;

  localparam logic [1:0] OP_PLACE  = 2'b00;
  localparam logic [1:0] OP_ATTACK = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WRITE, S_ATTACK, S_CLEAR, S_RESP
  } state_t;

  function automatic logic [IDX_W-1:0] cell_idx(input int b, input int r, input int c);
    return IDX_W'(b * N2 + r * BOARD_N + c);
  endfunction

  state_t             state_reg;
  logic [1:0]         cells [CELLS];
  logic               cap_board;
  logic               cap_vert;
  logic [COORD_W-1:0] cap_row;
  logic [COORD_W-1:0] cap_col;
  logic [2:0]         cap_len;
  logic [CNT_W-1:0]   cnt_reg;
  logic               overlap_reg;
  logic               ready_reg;
  logic               resp_valid_reg;
  logic [2:0]         resp_code_reg;
  logic [1:0]         rd_cell_reg;
  logic [1:0][2:0]    ships_reg;
  logic [1:0][4:0]    left_reg;

  int                 step_row;
  int                 step_col;
  int                 place_end;
  int                 place_side;
  logic [IDX_W-1:0]   step_idx;
  logic [IDX_W-1:0]   clr_idx;
  logic [IDX_W-1:0]   atk_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               step_last;
  logic               place_full;
  logic               place_bad;
  logic               atk_bad;
  logic               rd_ok;

  assign cmd.cmd_ready  = ready_reg;
  assign cmd.resp_valid = resp_valid_reg;
  assign cmd.resp_code  = resp_code_reg;
  assign rd_cell        = rd_cell_reg;
  assign ships_placed   = ships_reg;
  assign cells_left     = left_reg;

  // A board is defeated only once it holds ships and every ship cell is hit.
  for (genvar gi = 0; gi < 2; gi++) begin : g_defeat
    assign defeated[gi] = (ships_reg[gi] != 3'd0) && (left_reg[gi] == 5'd0);
  end

  // Address generation for the walking states and acceptance-time checks.
  always_comb begin
    step_row   = int'(cap_row) + (cap_vert ? int'(cnt_reg) : 0);
    step_col   = int'(cap_col) + (cap_vert ? 0 : int'(cnt_reg));
    step_idx   = cell_idx(int'(cap_board), step_row, step_col);
    step_last  = (int'(cnt_reg) == int'(cap_len) - 1);
    clr_idx    = IDX_W'(int'(cap_board) * N2 + int'(cnt_reg));
    atk_idx    = cell_idx(int'(cap_board), int'(cap_row), int'(cap_col));
    place_end  = (cmd.cmd_vert ? int'(cmd.cmd_row) : int'(cmd.cmd_col)) + int'(cmd.cmd_len) - 1;
    place_side = cmd.cmd_vert ? int'(cmd.cmd_col) : int'(cmd.cmd_row);
    place_full = int'(ships_reg[cmd.cmd_board]) >= MAX_SHIPS;
    // The anchor's fixed coordinate must also lie on the board.
    place_bad  = (cmd.cmd_len == 3'd0) || (int'(cmd.cmd_len) > MAX_LEN) ||
                 (place_end >= BOARD_N) || (place_side >= BOARD_N);
    atk_bad    = (int'(cmd.cmd_row) >= BOARD_N) || (int'(cmd.cmd_col) >= BOARD_N);
    rd_ok      = (int'(rd_row) < BOARD_N) && (int'(rd_col) < BOARD_N);
    rd_idx     = rd_ok ? cell_idx(int'(rd_board), int'(rd_row), int'(rd_col)) : '0;
  end

  // Command FSM: accepts in IDLE, walks cells one per cycle, issues one response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      ready_reg      <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_code_reg  <= R_PLACED;
      ships_reg      <= '0;
      left_reg       <= '0;
      cnt_reg        <= '0;
      overlap_reg    <= 1'b0;
      cap_board      <= 1'b0;
      cap_vert       <= 1'b0;
      cap_row        <= '0;
      cap_col        <= '0;
      cap_len        <= '0;
      for (int i = 0; i < CELLS; i++) cells[i] <= WATER;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            cap_board   <= cmd.cmd_board;
            cap_vert    <= cmd.cmd_vert;
            cap_row     <= cmd.cmd_row;
            cap_col     <= cmd.cmd_col;
            cap_len     <= cmd.cmd_len;
            cnt_reg     <= '0;
            overlap_reg <= 1'b0;
            ready_reg   <= 1'b0;
            case (cmd.cmd_op)
              OP_PLACE: begin
                if (place_full) begin
                  state_reg      <= S_RESP;
                  resp_valid_reg <= 1'b1;
                  resp_code_reg  <= R_ERR_FULL;
                end else if (place_bad) begin
                  state_reg      <= S_RESP;
                  resp_valid_reg <= 1'b1;
                  resp_code_reg  <= R_ERR_BOUNDS;
                end else begin
                  state_reg <= S_CHECK;
                end
              end
              OP_ATTACK: begin
                if (atk_bad) begin
                  state_reg      <= S_RESP;
                  resp_valid_reg <= 1'b1;
                  resp_code_reg  <= R_ERR_OP;
                end else begin
                  state_reg <= S_ATTACK;
                end
              end
              OP_CLEAR: state_reg <= S_CLEAR;
              default: begin
                state_reg      <= S_RESP;
                resp_valid_reg <= 1'b1;
                resp_code_reg  <= R_ERR_OP;
              end
            endcase
          end
        end
        S_CHECK: begin
          // Every cell of the ship is visited even after an overlap is seen.
          if (cells[step_idx] != WATER) overlap_reg <= 1'b1;
          if (step_last) begin
            cnt_reg <= '0;
            if (overlap_reg || (cells[step_idx] != WATER)) begin
              state_reg      <= S_RESP;
              resp_valid_reg <= 1'b1;
              resp_code_reg  <= R_ERR_OVERLAP;
            end else begin
              state_reg <= S_WRITE;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_WRITE: begin
          cells[step_idx] <= SHIP;
          if (step_last) begin
            ships_reg[cap_board] <= ships_reg[cap_board] + 3'd1;
            left_reg[cap_board]  <= left_reg[cap_board] + 5'(cap_len);
            state_reg            <= S_RESP;
            resp_valid_reg       <= 1'b1;
            resp_code_reg        <= R_PLACED;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_ATTACK: begin
          state_reg      <= S_RESP;
          resp_valid_reg <= 1'b1;
          case (cells[atk_idx])
            SHIP: begin
              cells[atk_idx]      <= HIT_SHIP;
              left_reg[cap_board] <= left_reg[cap_board] - 5'd1;
              resp_code_reg       <= R_HIT;
            end
            WATER: begin
              cells[atk_idx] <= HIT_WATER;
              resp_code_reg  <= R_MISS;
            end
            default: resp_code_reg <= R_REPEAT;
          endcase
        end
        S_CLEAR: begin
          cells[clr_idx] <= WATER;
          if (int'(cnt_reg) == N2 - 1) begin
            ships_reg[cap_board] <= 3'd0;
            left_reg[cap_board]  <= 5'd0;
            state_reg            <= S_RESP;
            resp_valid_reg       <= 1'b1;
            resp_code_reg        <= R_PLACED;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_RESP: begin
          resp_valid_reg <= 1'b0;
          ready_reg      <= 1'b1;
          state_reg      <= S_IDLE;
        end
        default: begin
          state_reg      <= S_IDLE;
          ready_reg      <= 1'b1;
          resp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Renderer read port: one-cycle latency, shows the pre-write value on a collision.
  always_ff @(posedge clk) begin
    if (!rst) rd_cell_reg <= WATER;
    else      rd_cell_reg <= rd_ok ? cells[rd_idx] : WATER;
  end

endmodule

// File: tb/tb_battleship_board_ctrl.sv
// Self-checking bench for battleship_board_ctrl: directed scenarios plus
// randomized commands checked against a board-level reference model.
module tb_battleship_board_ctrl;

  localparam int N    = 5;
  localparam int MAXS = 5;
  localparam int MAXL = 3;

  logic clk = 1'b0;
  logic rst;

  battleship_board_ctrl_if #(.COORD_W(3)) bus ();
  logic            rd_board;
  logic [2:0]      rd_row, rd_col;
  logic [1:0]      rd_cell;
  logic [1:0][2:0] ships_placed;
  logic [1:0][4:0] cells_left;
  logic [1:0]      defeated;

  battleship_board_ctrl_if #(.COORD_W(3)) bus7 ();
  logic            rd7_board;
  logic [2:0]      rd7_row, rd7_col;
  logic [1:0]      rd7_cell;
  logic [1:0][2:0] ships7;
  logic [1:0][4:0] left7;
  logic [1:0]      def7;

  int vec_count = 0;
  int err_count = 0;

  // Reference model: cell contents per board, ship and unhit-cell counts.
  int mcell [2][8][8];
  int mships [2];
  int mleft [2];

  always #5 clk = ~clk;

  battleship_board_ctrl #(.BOARD_N(N), .COORD_W(3), .MAX_SHIPS(MAXS), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .cmd(bus),
    .rd_board(rd_board), .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell),
    .ships_placed(ships_placed), .cells_left(cells_left), .defeated(defeated)
  );

  battleship_board_ctrl #(.BOARD_N(7), .COORD_W(3), .MAX_SHIPS(MAXS), .MAX_LEN(MAXL)) dut7 (
    .clk(clk), .rst(rst), .cmd(bus7),
    .rd_board(rd7_board), .rd_row(rd7_row), .rd_col(rd7_col), .rd_cell(rd7_cell),
    .ships_placed(ships7), .cells_left(left7), .defeated(def7)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    vec_count++;
    if (got != exp) begin
      err_count++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      mships[b] = 0;
      mleft[b]  = 0;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) mcell[b][r][c] = 0;
    end
  endtask

  // Applies one command to the model; returns expected code and response cycle.
  task automatic model_cmd(input int op, input int b, input int r, input int c,
                           input int len, input int v, output int code, output int lat);
    int endc, side;
    bit ovl;
    code = 7;
    lat  = 1;
    case (op)
      0: begin
        endc = (v != 0 ? r : c) + len - 1;
        side = (v != 0) ? c : r;
        if (mships[b] == MAXS) begin
          code = 3; lat = 1;
        end else if (len == 0 || len > MAXL || endc >= N || side >= N) begin
          code = 1; lat = 1;
        end else begin
          ovl = 0;
          for (int k = 0; k < len; k++)
            if (mcell[b][v != 0 ? r + k : r][v != 0 ? c : c + k] != 0) ovl = 1;
          if (ovl) begin
            code = 2; lat = len + 1;
          end else begin
            for (int k = 0; k < len; k++) mcell[b][v != 0 ? r + k : r][v != 0 ? c : c + k] = 1;
            mships[b] += 1;
            mleft[b]  += len;
            code = 0; lat = 2 * len + 1;
          end
        end
      end
      1: begin
        lat = 2;
        if (r >= N || c >= N) begin
          code = 7; lat = 1;
        end else if (mcell[b][r][c] == 1) begin
          mcell[b][r][c] = 2; mleft[b] -= 1; code = 4;
        end else if (mcell[b][r][c] == 0) begin
          mcell[b][r][c] = 3; code = 5;
        end else begin
          code = 6;
        end
      end
      2: begin
        for (int rr = 0; rr < 8; rr++)
          for (int cc = 0; cc < 8; cc++) mcell[b][rr][cc] = 0;
        mships[b] = 0;
        mleft[b]  = 0;
        code = 0; lat = N * N + 1;
      end
      default: begin
        code = 7; lat = 1;
      end
    endcase
  endtask

  task automatic check_status();
    for (int b = 0; b < 2; b++) begin
      check_val($sformatf("ships_placed[%0d]", b), int'(ships_placed[b]), mships[b]);
      check_val($sformatf("cells_left[%0d]", b), int'(cells_left[b]), mleft[b]);
      check_val($sformatf("defeated[%0d]", b), int'(defeated[b]),
                (mships[b] > 0 && mleft[b] == 0) ? 1 : 0);
      check_val($sformatf("cells_left_bound[%0d]", b),
                (int'(cells_left[b]) <= MAXS * MAXL) ? 1 : 0, 1);
    end
  endtask

  // Reads every address of both boards (including off-board ones) via the read port.
  task automatic sweep();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          rd_board = b[0];
          rd_row   = r[2:0];
          rd_col   = c[2:0];
          @(posedge clk);
          @(negedge clk);
          check_val($sformatf("cell b%0d r%0d c%0d", b, r, c), int'(rd_cell), mcell[b][r][c]);
        end
  endtask

  // Issues one command starting at a falling edge; ends at a falling edge with the engine idle.
  task automatic do_cmd(input int op, input int b, input int r, input int c,
                        input int len, input int v, output int code, output int lat);
    int exp_code, exp_lat, pre, post;
    bit track;
    track = (op == 1 && r < N && c < N);
    pre   = track ? mcell[b][r][c] : 0;
    model_cmd(op, b, r, c, len, v, exp_code, exp_lat);
    post  = track ? mcell[b][r][c] : 0;
    if (track) begin
      rd_board = b[0]; rd_row = r[2:0]; rd_col = c[2:0];
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op[1:0];
    bus.cmd_board = b[0];
    bus.cmd_row   = r[2:0];
    bus.cmd_col   = c[2:0];
    bus.cmd_len   = len[2:0];
    bus.cmd_vert  = v[0];
    check_val("ready_idle", int'(bus.cmd_ready), 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_board = 1'($urandom);
    bus.cmd_row   = 3'($urandom);
    bus.cmd_col   = 3'($urandom);
    bus.cmd_len   = 3'($urandom);
    bus.cmd_vert  = 1'($urandom);
    lat = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.resp_valid) break;
      check_val("ready_busy", int'(bus.cmd_ready), 0);
      lat++;
    end
    check_val("resp_seen", int'(bus.resp_valid), 1);
    code = int'(bus.resp_code);
    check_val("resp_code", code, exp_code);
    check_val("resp_cycle", lat, exp_lat);
    check_val("ready_resp", int'(bus.cmd_ready), 0);
    check_status();
    if (track) check_val("rd_prewrite", int'(rd_cell), pre);
    @(negedge clk);
    check_val("resp_one_cycle", int'(bus.resp_valid), 0);
    if (track) check_val("rd_postwrite", int'(rd_cell), post);
    $display("txn op=%0d board=%0d row=%0d col=%0d len=%0d vert=%0d -> code=%0d cycle=%0d (exp %0d/%0d)",
             op, b, r, c, len, v, code, lat, exp_code, exp_lat);
  endtask

  task automatic do_cmd7(input int op, input int r, input int c, input int len,
                         input int v, input int exp_code, input int exp_lat);
    int lat;
    bus7.cmd_valid = 1'b1;
    bus7.cmd_op    = op[1:0];
    bus7.cmd_board = 1'b0;
    bus7.cmd_row   = r[2:0];
    bus7.cmd_col   = c[2:0];
    bus7.cmd_len   = len[2:0];
    bus7.cmd_vert  = v[0];
    @(posedge clk);
    #1;
    bus7.cmd_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus7.resp_valid) break;
      lat++;
    end
    check_val("n7_resp_seen", int'(bus7.resp_valid), 1);
    check_val("n7_resp_code", int'(bus7.resp_code), exp_code);
    check_val("n7_resp_cycle", lat, exp_lat);
    @(negedge clk);
    $display("txn7 op=%0d row=%0d col=%0d len=%0d vert=%0d -> code=%0d cycle=%0d",
             op, r, c, len, v, int'(bus7.resp_code), lat);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int code, lat, op, b, r, c, len, v, sel;
    rst = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_board = 1'b0;
    bus.cmd_row = 3'd0; bus.cmd_col = 3'd0; bus.cmd_len = 3'd0; bus.cmd_vert = 1'b0;
    bus7.cmd_valid = 1'b0; bus7.cmd_op = 2'd0; bus7.cmd_board = 1'b0;
    bus7.cmd_row = 3'd0; bus7.cmd_col = 3'd0; bus7.cmd_len = 3'd0; bus7.cmd_vert = 1'b0;
    rd_board = 1'b0; rd_row = 3'd0; rd_col = 3'd0;
    rd7_board = 1'b0; rd7_row = 3'd0; rd7_col = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", int'(bus.cmd_ready), 1);
    check_val("rst_resp_valid", int'(bus.resp_valid), 0);
    check_val("rst_resp_code", int'(bus.resp_code), 0);
    check_val("rst_rd_cell", int'(rd_cell), 0);
    check_status();
    rst = 1'b1;

    // Placement, overlap and bounds on the player board.
    do_cmd(0, 0, 1, 1, 3, 0, code, lat);
    check_val("plan_place_cycle", lat, 7);
    check_val("plan_place_code", code, 0);
    check_val("plan_place_ships", int'(ships_placed[0]), 1);
    check_val("plan_place_left", int'(cells_left[0]), 3);
    sweep();
    do_cmd(0, 0, 0, 2, 3, 1, code, lat);
    check_val("plan_overlap_cycle", lat, 4);
    check_val("plan_overlap_code", code, 2);
    do_cmd(0, 0, 3, 4, 2, 0, code, lat);
    check_val("plan_bounds_cycle", lat, 1);
    check_val("plan_bounds_code", code, 1);
    sweep();

    // Attacks and defeat on the PC board.
    do_cmd(0, 1, 2, 2, 2, 0, code, lat);
    do_cmd(0, 1, 4, 0, 1, 1, code, lat);
    do_cmd(1, 1, 2, 2, 0, 0, code, lat);
    check_val("plan_hit_cycle", lat, 2);
    check_val("plan_hit_code", code, 4);
    do_cmd(1, 1, 2, 2, 0, 0, code, lat);
    check_val("plan_repeat_code", code, 6);
    check_val("plan_repeat_left", int'(cells_left[1]), 2);
    do_cmd(1, 1, 0, 0, 0, 0, code, lat);
    check_val("plan_miss_code", code, 5);
    do_cmd(1, 1, 2, 3, 0, 0, code, lat);
    do_cmd(1, 1, 4, 0, 0, 0, code, lat);
    check_val("plan_defeated", int'(defeated[1]), 1);
    do_cmd(1, 1, 5, 0, 0, 0, code, lat);
    check_val("plan_attack_oob", code, 7);
    do_cmd(3, 0, 0, 0, 0, 0, code, lat);
    check_val("plan_reserved_op", code, 7);
    do_cmd(2, 1, 0, 0, 0, 0, code, lat);
    check_val("plan_clear_cycle", lat, 26);
    check_val("plan_clear_code", code, 0);
    check_val("plan_clear_defeated", int'(defeated[1]), 0);
    sweep();

    // Fill the player board to the ship limit.
    do_cmd(0, 0, 3, 0, 1, 0, code, lat);
    do_cmd(0, 0, 3, 2, 1, 0, code, lat);
    do_cmd(0, 0, 4, 0, 2, 0, code, lat);
    do_cmd(0, 0, 0, 0, 1, 1, code, lat);
    do_cmd(0, 0, 4, 4, 1, 0, code, lat);
    check_val("plan_full_code", code, 3);
    check_val("plan_full_cycle", lat, 1);

    // Reset during the third cycle of a placement aborts it silently.
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_board = 1'b1;
    bus.cmd_row = 3'd0; bus.cmd_col = 3'd0; bus.cmd_len = 3'd3; bus.cmd_vert = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check_val("abort_c1_resp", int'(bus.resp_valid), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("abort_c2_resp", int'(bus.resp_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("abort_c3_resp", int'(bus.resp_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_val("abort_ready", int'(bus.cmd_ready), 1);
    for (int i = 0; i < 10; i++) begin
      check_val("abort_no_resp", int'(bus.resp_valid), 0);
      @(negedge clk);
    end
    check_status();
    sweep();

    // Randomized commands against the model.
    for (int t = 0; t < 160; t++) begin
      sel = $urandom_range(0, 99);
      op  = (sel < 45) ? 0 : (sel < 88) ? 1 : (sel < 94) ? 2 : 3;
      b   = $urandom_range(0, 1);
      v   = $urandom_range(0, 1);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 3);
      if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 7);
        c = $urandom_range(0, 7);
      end else begin
        r = $urandom_range(0, N - 1);
        c = $urandom_range(0, N - 1);
      end
      do_cmd(op, b, r, c, len, v, code, lat);
      if (t % 4 == 3) sweep();
    end
    sweep();

    // Seven-cell board instance.
    do_cmd7(0, 6, 4, 1, 1, 0, 3);
    rd7_board = 1'b0; rd7_row = 3'd6; rd7_col = 3'd4;
    @(posedge clk);
    @(negedge clk);
    check_val("n7_cell_6_4", int'(rd7_cell), 1);
    check_val("n7_ships", int'(ships7[0]), 1);
    check_val("n7_left", int'(left7[0]), 1);
    do_cmd7(1, 6, 6, 0, 0, 5, 2);
    do_cmd7(1, 7, 0, 0, 0, 7, 1);
    do_cmd7(0, 6, 3, 2, 0, 2, 3);
    do_cmd7(0, 0, 6, 2, 0, 1, 1);
    do_cmd7(1, 6, 4, 0, 0, 4, 2);
    check_val("n7_defeated", int'(def7[0]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
